// File: rtl/bcd_counter_7seg.sv
// Multi-digit BCD up/down counter with prescaled ticks, parallel load and a
// registered active-low seven-segment driver with optional leading-zero blanking.
module bcd_counter_7seg #(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   hex,
  output logic                  carry,
  output logic                  load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [8*DIGITS-1:0] hex_q, hex_d;
  logic                carry_q, carry_d;
  logic                load_err_q, load_err_d;
  logic                tick;
  logic                prop;
  logic [3:0]          nib;
  logic                zrun;
  logic [3:0]          hnib;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  always_comb begin
    tick       = en && (presc_q == PMAX);
    presc_d    = presc_q;
    bcd_d      = bcd_q;
    carry_d    = 1'b0;
    load_err_d = load_err_q;
    prop       = 1'b0;
    nib        = 4'd0;
    if (load) begin
      presc_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
        nib = load_val[4*i +: 4];
        if (nib > 4'd9) begin
          bcd_d[4*i +: 4] = 4'd0;
          load_err_d      = 1'b1;
        end else begin
          bcd_d[4*i +: 4] = nib;
        end
      end
    end else begin
      if (en) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        // prop carries the increment/borrow upward; still set after the top digit means wrap
        prop = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          nib = bcd_q[4*i +: 4];
          if (prop) begin
            if (up) begin
              if (nib == 4'd9) bcd_d[4*i +: 4] = 4'd0;
              else begin
                bcd_d[4*i +: 4] = nib + 4'd1;
                prop            = 1'b0;
              end
            end else begin
              if (nib == 4'd0) bcd_d[4*i +: 4] = 4'd9;
              else begin
                bcd_d[4*i +: 4] = nib - 4'd1;
                prop            = 1'b0;
              end
            end
          end
        end
        carry_d = prop;
      end
    end
  end

  // Scan from the top digit down so zrun tracks "this and all higher digits are zero"
  always_comb begin
    hex_d = '1;
    zrun  = 1'b1;
    hnib  = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hnib = bcd_q[4*i +: 4];
      zrun = zrun && (hnib == 4'd0);
      if (blank_lz && (i != 0) && zrun) hex_d[8*i +: 8] = 8'hFF;
      else                              hex_d[8*i +: 8] = seg7(hnib);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      bcd_q      <= '0;
      hex_q      <= '1;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      bcd_q      <= bcd_d;
      hex_q      <= hex_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign bcd      = bcd_q;
  assign hex      = hex_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_7seg.sv
// Bench for bcd_counter_7seg: three instances (6x1, 2x1, 4x4 digits x divider),
// directed vector table, hand sequences and random stimulus against a value model.
module tb_bcd_counter_7seg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, up = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [23:0] lv = '0;

  logic [23:0] bcd_a;  logic [47:0] hex_a;  logic carry_a, err_a;
  logic [7:0]  bcd_b;  logic [15:0] hex_b;  logic carry_b, err_b;
  logic [15:0] bcd_c;  logic [31:0] hex_c;  logic carry_c, err_c;

  always #5 clk = ~clk;

  bcd_counter_7seg #(.DIGITS(6), .TICK_DIV(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .blank_lz(blank_lz), .bcd(bcd_a), .hex(hex_a), .carry(carry_a), .load_err(err_a));
  bcd_counter_7seg #(.DIGITS(2), .TICK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .blank_lz(blank_lz), .bcd(bcd_b), .hex(hex_b), .carry(carry_b), .load_err(err_b));
  bcd_counter_7seg #(.DIGITS(4), .TICK_DIV(4)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[15:0]),
    .blank_lz(blank_lz), .bcd(bcd_c), .hex(hex_c), .carry(carry_c), .load_err(err_c));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Model of instances a (index 0) and c (index 1): count kept as a plain integer
  int          m_nd  [2] = '{6, 4};
  int          m_dv  [2] = '{1, 4};
  longint      m_val [2];
  int          m_psc [2];
  bit          m_car [2];
  bit          m_err [2];
  logic [63:0] m_hex [2];

  function automatic longint p10(int e);
    longint r = 1;
    repeat (e) r = r * 10;
    return r;
  endfunction

  function automatic logic [63:0] hex_of(longint v, int nd, bit blz);
    logic [63:0] h = '0;
    for (int i = 0; i < nd; i++) begin
      int d = int'((v / p10(i)) % 10);
      if (blz && i > 0 && v < p10(i)) h[8*i +: 8] = 8'hFF;
      else                            h[8*i +: 8] = SEG[d];
    end
    return h;
  endfunction

  function automatic logic [63:0] bcd_of(longint v, int nd);
    logic [63:0] r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_psc[k] = 0; m_car[k] = 0; m_err[k] = 0; m_hex[k] = '1;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      longint      n   = p10(m_nd[k]);
      logic [31:0] lvk = (k == 0) ? {8'h0, lv} : {16'h0, lv[15:0]};
      bit          tk  = en && (m_psc[k] == m_dv[k] - 1);
      m_hex[k] = hex_of(m_val[k], m_nd[k], blank_lz);
      m_car[k] = 1'b0;
      if (load) begin
        longint v = 0;
        m_psc[k] = 0;
        for (int i = 0; i < m_nd[k]; i++) begin
          int nb = int'(lvk[4*i +: 4]);
          if (nb > 9) m_err[k] = 1'b1;
          else        v = v + nb * p10(i);
        end
        m_val[k] = v;
      end else begin
        if (en) m_psc[k] = tk ? 0 : m_psc[k] + 1;
        if (tk) begin
          if (up) begin
            m_car[k] = (m_val[k] == n - 1);
            m_val[k] = (m_val[k] + 1) % n;
          end else begin
            m_car[k] = (m_val[k] == 0);
            m_val[k] = (m_val[k] + n - 1) % n;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(int k);
    logic [63:0] b = (k == 0) ? 64'(bcd_a) : 64'(bcd_c);
    logic [63:0] h = (k == 0) ? 64'(hex_a) : 64'(hex_c);
    logic        c = (k == 0) ? carry_a : carry_c;
    logic        e = (k == 0) ? err_a : err_c;
    logic [63:0] hm = m_hex[k] & ((64'd1 << (8*m_nd[k])) - 64'd1);
    chk($sformatf("rnd%0d_bcd", k), b, bcd_of(m_val[k], m_nd[k]));
    chk($sformatf("rnd%0d_hex", k), h, hm);
    chk($sformatf("rnd%0d_carry", k), 64'(c), 64'(m_car[k]));
    chk($sformatf("rnd%0d_err", k), 64'(e), 64'(m_err[k]));
  endtask

  typedef struct {
    bit         ld;
    logic [7:0] val;
    bit         en;
    bit         up;
    logic [7:0] ebcd;
    bit         ecar;
    bit         eerr;
    logic [15:0] ehex;
  } vec_t;

  vec_t tv [15];

  initial begin
    tv[0]  = '{1'b1, 8'h09, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 16'hC0C0};
    tv[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 16'hC090};
    tv[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 16'hF9C0};
    tv[3]  = '{1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 16'hF9C0};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 16'h9090};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'hC0C0};
    tv[6]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 16'hC0C0};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 16'hF9C0};
    tv[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hC090};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 16'hC0C0};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 16'h9090};
    tv[11] = '{1'b1, 8'hA7, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 16'h9090};
    tv[12] = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 16'hC0F8};
    tv[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h56, 1'b0, 1'b1, 16'h9292};
    tv[14] = '{1'b1, 8'h3F, 1'b1, 1'b1, 8'h30, 1'b0, 1'b1, 16'h9282};

    // Reset state and first valid display
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_bcd", 64'(bcd_a), 64'd0);
    chk("rst_hex", 64'(hex_a), 64'hFFFF_FFFF_FFFF);
    chk("rst_carry", 64'(carry_a), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    rst = 1'b0;
    step();
    chk("first_hex0", 64'(hex_a[7:0]), 64'hC0);
    chk("first_bcd", 64'(bcd_a), 64'd0);

    // Directed vectors on the two-digit instance
    for (int r = 0; r < 15; r++) begin
      load = tv[r].ld; lv = {16'h0, tv[r].val}; en = tv[r].en; up = tv[r].up; blank_lz = 1'b0;
      step();
      chk($sformatf("vec%0d_bcd", r), 64'(bcd_b), 64'(tv[r].ebcd));
      chk($sformatf("vec%0d_carry", r), 64'(carry_b), 64'(tv[r].ecar));
      chk($sformatf("vec%0d_err", r), 64'(err_b), 64'(tv[r].eerr));
      chk($sformatf("vec%0d_hex", r), 64'(hex_b), 64'(tv[r].ehex));
    end

    // Asynchronous reset between edges clears everything at once
    load = 1'b0; en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_bcd_b", 64'(bcd_b), 64'd0);
    chk("midrst_hex_b", 64'(hex_b), 64'hFFFF);
    chk("midrst_err_b", 64'(err_b), 64'd0);
    chk("midrst_bcd_a", 64'(bcd_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("postrst_hex_b", 64'(hex_b), 64'hC0C0);

    // Leading-zero blanking on the four-digit instance
    load = 1'b1; lv = 24'h000050; blank_lz = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("blank_on", 64'(hex_c), 64'hFFFF_92C0);
    blank_lz = 1'b0;
    step();
    chk("blank_off", 64'(hex_c), 64'hC0C0_92C0);
    load = 1'b1; lv = 24'h0; blank_lz = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("blank_zero", 64'(hex_c), 64'hFFFF_FFC0);
    blank_lz = 1'b0;

    // Prescaler: a tick every fourth enabled cycle
    en = 1'b1; up = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 3)  chk("psc_c3", 64'(bcd_c), 64'h0000);
      if (c == 4)  chk("psc_c4", 64'(bcd_c), 64'h0001);
      if (c == 12) chk("psc_c12", 64'(bcd_c), 64'h0003);
    end
    en = 1'b0;
    repeat (3) step();
    chk("psc_gap", 64'(bcd_c), 64'h0003);
    en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    step();
    chk("psc_frozen", 64'(bcd_c), 64'h0003);
    step();
    chk("psc_resume", 64'(bcd_c), 64'h0004);

    // Load coinciding with a tick: load wins and the prescaler restarts
    repeat (3) step();
    load = 1'b1; lv = 24'h000123;
    step();
    load = 1'b0;
    chk("ldtick_bcd", 64'(bcd_c), 64'h0123);
    chk("ldtick_carry", 64'(carry_c), 64'd0);
    repeat (3) step();
    chk("ldtick_wait", 64'(bcd_c), 64'h0123);
    step();
    chk("ldtick_next", 64'(bcd_c), 64'h0124);

    // Random stimulus against the model, with periodic resets
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        #2 rst = 1'b1;
        #1 model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      load = ($urandom_range(0, 7) == 0);
      lv   = '0;
      for (int i = 0; i < 6; i++) lv[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) lv[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) == 1;
      blank_lz = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 11) == 0) begin
        load = 1'b1;
        lv   = up ? 24'h999999 : 24'h000000;
        if (!up && $urandom_range(0, 1) == 1) lv = 24'h009999;
      end
      step();
      chk_model(0);
      chk_model(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
